bus_arbiter: RTL and testbench
==============================

BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter MAX_HOLD, default 16, SHALL set the max consecutive granted cycles before forced handover when the other master is pending (range 2..255).
REQ-002 Port clk  input  1  sole clock; all state SHALL change on its rising edge.
REQ-003 Port rst  input  1  SHALL be an asynchronous, active-high reset.
REQ-004 Ports m0_req, m1_req  input  1 each  master bus request, held high for the whole transfer sequence.
REQ-005 Ports m0_addr, m1_addr  input  13 each  master address.
REQ-006 Ports m0_rd, m0_wr, m1_rd, m1_wr  input  1 each  master read/write strobes.
REQ-007 Ports m0_wdata, m1_wdata  input  8 each  master write data.
REQ-008 Ports m0_gnt, m1_gnt  output  1 each  registered grant, one-hot or zero.
REQ-009 Ports bus_addr  output  13, bus_rd, bus_wr  output  1, bus_wdata  output  8  shared bus to address decoder, ROM and RAM.
REQ-010 Port bus_wdata_oe  output  1  high only when the owner asserts wr; enables the tri-state data driver.

Function
REQ-011 FSM states SHALL be IDLE, OWN0, OWN1, TURN; m0_gnt=1 only in OWN0, m1_gnt=1 only in OWN1.
REQ-012 IDLE: single request -> own that master next cycle; both -> master other than last_owner; none -> stay.
REQ-013 OWNx with reqx dropped: other req high -> TURN; else IDLE; grant SHALL deassert the following cycle.
REQ-014 OWNx with reqx high SHALL be retained unless hold limit (REQ-020) fires.
REQ-015 TURN SHALL last exactly one cycle with bus_rd=bus_wr=bus_wdata_oe=0, then enter OWN of the pending master; if it dropped, IDLE.
REQ-016 Bus outputs SHALL be a combinational mux of the owner's addr/rd/wr/wdata in OWNx; in IDLE/TURN all bus outputs SHALL be 0.
REQ-017 rd and wr both high from the owner SHALL be forwarded as rd only (wr suppressed).
REQ-018 Grant latency: request in IDLE at edge N -> gnt high after edge N+1; handover via TURN -> new gnt high two edges after old req drop.
REQ-019 last_owner SHALL update on every entry to OWN0/OWN1.

Reset
REQ-020 (conditional, see Configuration) hold counter SHALL count granted cycles from 1; at MAX_HOLD with other req high, owner SHALL be revoked to TURN regardless of its req.
REQ-021 rst SHALL immediately force IDLE, both gnt 0, all bus outputs 0, hold counter 0, last_owner=1 (m0 wins first tie).
REQ-022 rst asserted mid-transfer SHALL abort without completing the cycle; after release, arbitration restarts from IDLE.

Configuration
REQ-023 Macro BUS_ARBITER_HOLD_LIMIT_EN defined: REQ-020 active, MAX_HOLD honoured.
REQ-024 Macro undefined: no hold counter; owner keeps bus until it drops req; MAX_HOLD ignored.

Structure
REQ-025 Shared package risc_bus_pkg SHALL hold ADDR_W=13, DATA_W=8 and the arbiter state enum.
REQ-026 One sub-module arb_hold_counter (saturating counter, clear/enable/limit-hit) SHALL be instantiated only under BUS_ARBITER_HOLD_LIMIT_EN.

Verification
REQ-027 Reset then m0_req=1, addr=0x1ABC, rd=1 -> m0_gnt=1 next cycle, bus_addr=0x1ABC, bus_rd=1.
REQ-028 m0_req and m1_req rise same cycle after reset -> m0 granted; m0 drops -> one TURN cycle with bus idle, then m1_gnt=1.
REQ-029 Both requesting continuously, limit enabled, MAX_HOLD=4 -> grant alternates every 4 granted cycles with TURN between; limit disabled -> m0 owns indefinitely.
REQ-030 Owner drives rd=wr=1, wdata=0x5A -> bus_rd=1, bus_wr=0, bus_wdata_oe=0.
REQ-031 rst pulsed during OWN1 write -> gnt, bus_wr, bus_wdata_oe low asynchronously; after release with both req high -> m0 granted.
REQ-032 m1 only requests, drops, requests again -> OWN1, IDLE, OWN1, no TURN inserted.

Source files
------------

// File: rtl/risc_bus_pkg.sv
// Shared widths and arbiter state encoding for the two-master bus.
package risc_bus_pkg;

  localparam int unsigned ADDR_W = 13;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned HOLD_W = 8;

  typedef enum logic [1:0] {
    StIdle,
    StOwn0,
    StOwn1,
    StTurn
  } arb_state_e;

endpackage

// File: rtl/arb_hold_counter.sv
// Saturating count of consecutive granted cycles; flags when the hold limit is reached.
module arb_hold_counter
  import risc_bus_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              enable,
  input  logic [HOLD_W-1:0] limit,
  output logic              limit_hit
);

  logic [HOLD_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && (count_q != {HOLD_W{1'b1}})) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign limit_hit = (count_q >= limit);

endmodule

// File: rtl/bus_arbiter.sv
// Two-master bus arbiter with a one-cycle turnaround between owners.
// Define BUS_ARBITER_HOLD_LIMIT_EN to revoke an owner after MAX_HOLD granted cycles.
module bus_arbiter
  import risc_bus_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic              m1_req,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic              m0_rd,
  input  logic              m0_wr,
  input  logic              m1_rd,
  input  logic              m1_wr,
  input  logic [DATA_W-1:0] m0_wdata,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m0_gnt,
  output logic              m1_gnt,
  output logic [ADDR_W-1:0] bus_addr,
  output logic              bus_rd,
  output logic              bus_wr,
  output logic [DATA_W-1:0] bus_wdata,
  output logic              bus_wdata_oe
);

  if ((MAX_HOLD < 2) || (MAX_HOLD > 255)) begin : gen_bad_max_hold
    $error("bus_arbiter: MAX_HOLD must be in 2..255");
  end

  arb_state_e state_q, state_d;
  logic       last_owner_q, last_owner_d;
  logic       own_next;
  logic       hold_hit;

  assign own_next = (state_d == StOwn0) || (state_d == StOwn1);

`ifdef BUS_ARBITER_HOLD_LIMIT_EN
  localparam logic [HOLD_W-1:0] HoldLimit = HOLD_W'(MAX_HOLD);

  // Count restarts at 1 on each entry to an owning state.
  arb_hold_counter u_hold_counter (
    .clk       (clk),
    .rst       (rst),
    .clear     (!own_next),
    .enable    (own_next),
    .limit     (HoldLimit),
    .limit_hit (hold_hit)
  );
`else
  assign hold_hit = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (m0_req && m1_req) begin
          state_d = last_owner_q ? StOwn0 : StOwn1;
        end else if (m0_req) begin
          state_d = StOwn0;
        end else if (m1_req) begin
          state_d = StOwn1;
        end
      end
      StOwn0: begin
        if (!m0_req || (hold_hit && m1_req)) begin
          state_d = m1_req ? StTurn : StIdle;
        end
      end
      StOwn1: begin
        if (!m1_req || (hold_hit && m0_req)) begin
          state_d = m0_req ? StTurn : StIdle;
        end
      end
      StTurn: begin
        // The pending master is always the one that did not own last.
        if (last_owner_q) begin
          state_d = m0_req ? StOwn0 : StIdle;
        end else begin
          state_d = m1_req ? StOwn1 : StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    last_owner_d = last_owner_q;
    if (state_d == StOwn0) begin
      last_owner_d = 1'b0;
    end else if (state_d == StOwn1) begin
      last_owner_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      last_owner_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
    end
  end

  assign m0_gnt = (state_q == StOwn0);
  assign m1_gnt = (state_q == StOwn1);

  always_comb begin
    bus_addr     = '0;
    bus_rd       = 1'b0;
    bus_wr       = 1'b0;
    bus_wdata    = '0;
    bus_wdata_oe = 1'b0;
    if (state_q == StOwn0) begin
      bus_addr  = m0_addr;
      bus_rd    = m0_rd;
      bus_wr    = m0_wr && !m0_rd;
      bus_wdata = m0_wdata;
    end else if (state_q == StOwn1) begin
      bus_addr  = m1_addr;
      bus_rd    = m1_rd;
      bus_wr    = m1_wr && !m1_rd;
      bus_wdata = m1_wdata;
    end
    // Read wins a simultaneous rd/wr, so the data driver follows the forwarded write.
    bus_wdata_oe = bus_wr;
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed self-checking bench for bus_arbiter, covering both hold-limit builds.
module tb_bus_arbiter;
  import risc_bus_pkg::*;

  logic              clk;
  logic              rst;
  logic              m0_req, m1_req;
  logic [ADDR_W-1:0] m0_addr, m1_addr;
  logic              m0_rd, m0_wr, m1_rd, m1_wr;
  logic [DATA_W-1:0] m0_wdata, m1_wdata;
  logic              m0_gnt, m1_gnt;
  logic [ADDR_W-1:0] bus_addr;
  logic              bus_rd, bus_wr;
  logic [DATA_W-1:0] bus_wdata;
  logic              bus_wdata_oe;

  int errors = 0;
  int checks = 0;

  bus_arbiter #(
    .MAX_HOLD (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .m0_req       (m0_req),
    .m1_req       (m1_req),
    .m0_addr      (m0_addr),
    .m1_addr      (m1_addr),
    .m0_rd        (m0_rd),
    .m0_wr        (m0_wr),
    .m1_rd        (m1_rd),
    .m1_wr        (m1_wr),
    .m0_wdata     (m0_wdata),
    .m1_wdata     (m1_wdata),
    .m0_gnt       (m0_gnt),
    .m1_gnt       (m1_gnt),
    .bus_addr     (bus_addr),
    .bus_rd       (bus_rd),
    .bus_wr       (bus_wr),
    .bus_wdata    (bus_wdata),
    .bus_wdata_oe (bus_wdata_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_bus_idle(input string tag);
    chk({tag, ".addr"}, 32'(bus_addr), 32'h0);
    chk({tag, ".rd"}, 32'(bus_rd), 32'h0);
    chk({tag, ".wr"}, 32'(bus_wr), 32'h0);
    chk({tag, ".wdata"}, 32'(bus_wdata), 32'h0);
    chk({tag, ".oe"}, 32'(bus_wdata_oe), 32'h0);
  endtask

  // {m1_gnt, m0_gnt} per cycle after m0 takes the bus with both masters requesting.
`ifdef BUS_ARBITER_HOLD_LIMIT_EN
  logic [1:0] hold_seq [11] = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b00,
                                2'b10, 2'b10, 2'b10, 2'b10, 2'b00, 2'b01};
`else
  logic [1:0] hold_seq [11] = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b01,
                                2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01};
`endif

  initial begin
    rst = 1'b1;
    m0_req = 1'b0; m1_req = 1'b0;
    m0_addr = '0; m1_addr = '0;
    m0_rd = 1'b0; m0_wr = 1'b0; m1_rd = 1'b0; m1_wr = 1'b0;
    m0_wdata = '0; m1_wdata = '0;

    // Reset state
    step();
    step();
    chk("rst.m0_gnt", 32'(m0_gnt), 32'h0);
    chk("rst.m1_gnt", 32'(m1_gnt), 32'h0);
    chk_bus_idle("rst.bus");
    #2 rst = 1'b0;
    step();
    chk("idle.m0_gnt", 32'(m0_gnt), 32'h0);
    chk("idle.m1_gnt", 32'(m1_gnt), 32'h0);

    // Single read request from m0
    m0_req = 1'b1; m0_addr = 13'h1ABC; m0_rd = 1'b1;
    step();
    chk("rd.m0_gnt", 32'(m0_gnt), 32'h1);
    chk("rd.m1_gnt", 32'(m1_gnt), 32'h0);
    chk("rd.bus_addr", 32'(bus_addr), 32'h1ABC);
    chk("rd.bus_rd", 32'(bus_rd), 32'h1);
    chk("rd.bus_wr", 32'(bus_wr), 32'h0);

    // rd and wr together forward as a read only
    m0_wr = 1'b1; m0_wdata = 8'h5A;
    #1;
    chk("rdwr.bus_rd", 32'(bus_rd), 32'h1);
    chk("rdwr.bus_wr", 32'(bus_wr), 32'h0);
    chk("rdwr.oe", 32'(bus_wdata_oe), 32'h0);
    m0_rd = 1'b0;
    #1;
    chk("wr.bus_wr", 32'(bus_wr), 32'h1);
    chk("wr.oe", 32'(bus_wdata_oe), 32'h1);
    chk("wr.bus_wdata", 32'(bus_wdata), 32'h5A);

    // Drop with no other request returns to idle
    m0_req = 1'b0;
    step();
    chk("drop.m0_gnt", 32'(m0_gnt), 32'h0);
    chk_bus_idle("drop.bus");

    // Reset restores m0 as tie winner, then handover through one turnaround
    #2 rst = 1'b1;
    #2 rst = 1'b0;
    m0_req = 1'b1; m0_rd = 1'b1; m0_wr = 1'b0;
    m1_req = 1'b1; m1_addr = 13'h0123; m1_wr = 1'b1; m1_wdata = 8'hC3;
    step();
    chk("tie.m0_gnt", 32'(m0_gnt), 32'h1);
    chk("tie.m1_gnt", 32'(m1_gnt), 32'h0);
    m0_req = 1'b0;
    step();
    chk("turn.m0_gnt", 32'(m0_gnt), 32'h0);
    chk("turn.m1_gnt", 32'(m1_gnt), 32'h0);
    chk_bus_idle("turn.bus");
    step();
    chk("hand.m1_gnt", 32'(m1_gnt), 32'h1);
    chk("hand.bus_addr", 32'(bus_addr), 32'h0123);
    chk("hand.bus_wr", 32'(bus_wr), 32'h1);
    chk("hand.oe", 32'(bus_wdata_oe), 32'h1);
    chk("hand.bus_wdata", 32'(bus_wdata), 32'hC3);

    // Asynchronous reset in the middle of the m1 write
    #2 rst = 1'b1;
    #1;
    chk("arst.m1_gnt", 32'(m1_gnt), 32'h0);
    chk("arst.bus_wr", 32'(bus_wr), 32'h0);
    chk("arst.oe", 32'(bus_wdata_oe), 32'h0);
    m0_req = 1'b1;
    #2 rst = 1'b0;
    step();
    chk("arst.m0_win", 32'(m0_gnt), 32'h1);
    chk("arst.m1_lose", 32'(m1_gnt), 32'h0);

    // Both requesting continuously: hold limit behaviour
    for (int i = 1; i < 11; i++) begin
      step();
      chk($sformatf("hold[%0d].gnt", i), 32'({m1_gnt, m0_gnt}), 32'(hold_seq[i]));
    end

    m0_req = 1'b0; m1_req = 1'b0;
    step();
    chk("quiet.gnt", 32'({m1_gnt, m0_gnt}), 32'h0);

    // m1 alone: request, drop, request again with no turnaround
    m1_req = 1'b1;
    step();
    chk("solo1.m1_gnt", 32'(m1_gnt), 32'h1);
    m1_req = 1'b0;
    step();
    chk("solo_drop.m1_gnt", 32'(m1_gnt), 32'h0);
    chk_bus_idle("solo_drop.bus");
    m1_req = 1'b1;
    step();
    chk("solo2.m1_gnt", 32'(m1_gnt), 32'h1);
    chk("solo2.bus_addr", 32'(bus_addr), 32'h0123);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
